serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
//
// PURPOSE
// Multi-cycle WIDTH-bit magnitude comparator. It scans the two operands MSB-first, DIGIT bits per cycle.
// A less/greater/equal cascade is carried from slice to slice, the same way the per-bit comparator chain does it.
// Supports unsigned or two's-complement compare, selected per operation, and optional early termination.
// Sits between operand registers and control logic that needs a registered lo/go/eo verdict with a start/done handshake.
//
// PARAMETERS
// WIDTH       8   operand width in bits; must be >= 2
// DIGIT       1   bits compared per cycle; WIDTH % DIGIT must be 0
// EARLY_EXIT  0   1 = finish as soon as a slice decides lt/gt; 0 = always scan all slices
//
// PORTS
// clk          in   1      rising-edge clock
// rst          in   1      synchronous, active-high reset
// start        in   1      request a compare; accepted only in IDLE
// signed_mode  in   1      1 = two's-complement compare, 0 = unsigned; sampled with start
// a            in   WIDTH  operand A; sampled when start is accepted
// b            in   WIDTH  operand B; sampled when start is accepted
// busy         out  1      high while state != IDLE
// done         out  1      one-cycle pulse: lo/go/eo are valid from this cycle on
// lo           out  1      result a < b
// go           out  1      result a > b
// eo           out  1      result a == b
//
// BEHAVIOUR
// - Definitions: N = WIDTH/DIGIT. Slice k (k = 1..N) is bits [WIDTH-1-(k-1)*DIGIT -: DIGIT].
// - Reset (rst high at a clk edge):
//   - state = IDLE; busy, done, lo, go and eo all 0.
//   - Internal operand copies and the cascade are cleared.
//   - Applies mid-operation: the in-flight compare is discarded and no done is issued.
// - FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 latches a, b and signed_mode; cascade (l,g,e) = (0,0,1); slice index = 1; go to RUN.
//   - RUN: each cycle compares one slice.
//     - If the cascade is already l or g, it holds.
//     - Otherwise, with e=1: slice_a > slice_b sets g; slice_a < slice_b sets l; equal slices keep e.
//     - Signed mode: slice 1 is compared with its top bit (operand bit WIDTH-1) inverted on both operands. All other slices compare unsigned.
//     - Leave RUN after slice N, or earlier when EARLY_EXIT=1 and the updated cascade is l or g.
//     - On leaving RUN: lo/go/eo <= the updated cascade; go to DONE.
//   - DONE: done=1 for exactly this cycle, then IDLE. start is ignored in DONE.
// - Latency: start accepted in cycle 0; slice k evaluated in cycle k; done in cycle N+1.
//   - With EARLY_EXIT=1, done comes in cycle k+1, where k is the first deciding slice.
//   - Back-to-back operations: the next start is accepted in cycle N+2 at the earliest.
// - Results:
//   - Exactly one of lo/go/eo is 1 after the first done.
//   - lo/go/eo hold their values until the next done or reset.
//   - They are not cleared when a new start is accepted.
// - start while busy=1: ignored, with no effect on the operation in flight.
// - a, b and signed_mode may change freely after acceptance; only the latched copies are used.
// - rst and start both high at the same edge: reset wins; the start is not accepted.
//
// TESTING
// 1. WIDTH=8, DIGIT=1, EARLY_EXIT=0; a=8'h5A, b=8'h5A, unsigned; start in cycle 0.
//    -> busy is high for cycles 1..9; done in cycle 9; eo=1, lo=go=0.
// 2. a=8'h80, b=8'h7F.
//    -> unsigned: go=1. signed_mode=1: lo=1. Both runs finish with done in cycle 9.
// 3. EARLY_EXIT=1, a=8'h80, b=8'h00, unsigned.
//    -> done in cycle 2 with go=1. a=8'h01, b=8'h00 -> done in cycle 9 with go=1.
// 4. WIDTH=16, DIGIT=4, a=16'h1234, b=16'h1243.
//    -> done in cycle 5, lo=1. Signed a=16'hFFFF (-1), b=16'h0001 -> lo=1.
// 5. Pulse start in cycles 3 and 5 during a run with a=8'h10, b=8'h20.
//    -> single done in cycle 9, lo=1. A start pulse in cycle 9 (DONE) is also ignored.
//    -> busy is low in cycle 10; a start in cycle 10 is accepted.
// 6. Assert rst in cycle 4 of a run.
//    -> cycle 5: busy=0, lo=go=eo=0, no done. A fresh start then completes normally.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first magnitude comparator: scans DIGIT bits per cycle and
// carries a less/greater/equal cascade from slice to slice. Signed
// operands are compared by inverting the sign bit of the leading slice.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIGIT      = 1,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lo,
    output logic             go,
    output logic             eo
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned IDX_W = $clog2(N + 1);

    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N);
    localparam logic [DIGIT-1:0] TOP_MASK  = DIGIT'(1) << (DIGIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [IDX_W-1:0] idx_q;
    logic             casc_l;
    logic             casc_g;
    logic             casc_e;

    logic [DIGIT-1:0] slice_a_c;
    logic [DIGIT-1:0] slice_b_c;
    logic             nxt_l_c;
    logic             nxt_g_c;
    logic             nxt_e_c;
    logic             run_last_c;

    // Current slice compare and cascade update; the operand copies shift
    // left each cycle so the active slice is always the top DIGIT bits.
    always_comb begin
        slice_a_c = a_q[WIDTH-1 -: DIGIT];
        slice_b_c = b_q[WIDTH-1 -: DIGIT];
        if (sgn_q && (idx_q == IDX_FIRST)) begin
            slice_a_c = slice_a_c ^ TOP_MASK;
            slice_b_c = slice_b_c ^ TOP_MASK;
        end

        nxt_l_c = casc_l;
        nxt_g_c = casc_g;
        nxt_e_c = casc_e;
        if (casc_e) begin
            if (slice_a_c > slice_b_c) begin
                nxt_g_c = 1'b1;
                nxt_e_c = 1'b0;
            end else if (slice_a_c < slice_b_c) begin
                nxt_l_c = 1'b1;
                nxt_e_c = 1'b0;
            end
        end

        run_last_c = (idx_q == IDX_LAST) || (EARLY_EXIT && !nxt_e_c);
    end

    // Control FSM, operand/cascade registers and registered verdict outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            idx_q  <= '0;
            casc_l <= 1'b0;
            casc_g <= 1'b0;
            casc_e <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            lo     <= 1'b0;
            go     <= 1'b0;
            eo     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        sgn_q  <= signed_mode;
                        idx_q  <= IDX_FIRST;
                        casc_l <= 1'b0;
                        casc_g <= 1'b0;
                        casc_e <= 1'b1;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    casc_l <= nxt_l_c;
                    casc_g <= nxt_g_c;
                    casc_e <= nxt_e_c;
                    a_q    <= a_q << DIGIT;
                    b_q    <= b_q << DIGIT;
                    if (run_last_c) begin
                        lo    <= nxt_l_c;
                        go    <= nxt_g_c;
                        eo    <= nxt_e_c;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: three configurations (8b bitwise,
// 8b bitwise with early exit, 16b nibble-wise) against an arithmetic model.
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start0, start1, start2;
    logic        sgn0, sgn1, sgn2;
    logic [7:0]  a0, b0, a1, b1;
    logic [15:0] a2, b2;
    logic        busy0, done0, lo0, go0, eo0;
    logic        busy1, done1, lo1, go1, eo1;
    logic        busy2, done2, lo2, go2, eo2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .signed_mode(sgn0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .lo(lo0), .go(go0), .eo(eo0));

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(sgn1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .lo(lo1), .go(go1), .eo(eo1));

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .signed_mode(sgn2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .lo(lo2), .go(go2), .eo(eo2));

    // Reference verdict {lo,go,eo} from plain integer comparison.
    function automatic logic [2:0] ref_cmp(int w, logic [15:0] av, logic [15:0] bv, logic s);
        longint ia, ib;
        ia = longint'(av);
        ib = longint'(bv);
        if (s && av[4'(w - 1)]) ia = ia - (longint'(1) << w);
        if (s && bv[4'(w - 1)]) ib = ib - (longint'(1) << w);
        if (ia < ib) return 3'b100;
        if (ia > ib) return 3'b010;
        return 3'b001;
    endfunction

    // Index (1-based, MSB-first) of the first slice where the operands differ; 0 if none.
    function automatic int ref_first_diff(int w, int d, logic [15:0] av, logic [15:0] bv);
        logic [15:0] m;
        m = 16'((1 << d) - 1);
        for (int k = 1; k <= w / d; k++) begin
            if (((av >> (w - k * d)) & m) != ((bv >> (w - k * d)) & m)) return k;
        end
        return 0;
    endfunction

    function automatic logic [4:0] obs(int sel);
        case (sel)
            0:       return {busy0, done0, lo0, go0, eo0};
            1:       return {busy1, done1, lo1, go1, eo1};
            default: return {busy2, done2, lo2, go2, eo2};
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic set_ops(input int sel, input logic [15:0] av, input logic [15:0] bv, input logic sv);
        case (sel)
            0:       begin a0 = av[7:0]; b0 = bv[7:0]; sgn0 = sv; end
            1:       begin a1 = av[7:0]; b1 = bv[7:0]; sgn1 = sv; end
            default: begin a2 = av;      b2 = bv;      sgn2 = sv; end
        endcase
    endtask

    // Launch one compare from a negedge (cycle 0) and observe cycles 1..budget.
    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input int pulse_mask, input int budget,
                          output int done_cyc, output int n_done, output int busy_cnt,
                          output logic [2:0] res, output logic [2:0] res_c1,
                          output logic [1:0] after);
        logic [4:0] o;
        done_cyc = -1; n_done = 0; busy_cnt = 0; res = 'x; res_c1 = 'x;
        set_ops(sel, av, bv, sv);
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ops(sel, 16'($urandom), 16'($urandom), 1'($urandom));
        for (int c = 1; c <= budget; c++) begin
            o = obs(sel);
            if (c == 1) res_c1 = o[2:0];
            if (o[4]) busy_cnt++;
            if (o[3]) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = c; res = o[2:0]; end
            end
            set_start(sel, pulse_mask[c]);
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        o = obs(sel);
        if (o[3]) n_done++;
        after = o[4:3];
    endtask

    task automatic test_reset;
        logic [4:0] o;
        rst = 1'b1;
        start0 = 0; start1 = 0; start2 = 0;
        set_ops(0, 0, 0, 0); set_ops(1, 0, 0, 0); set_ops(2, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            o = obs(s);
            total_cnt++;
            if (o !== 5'b0) $display("FAIL reset_state dut%0d: got %b want 00000", s, o);
            else pass_cnt++;
        end
    endtask

    task automatic test_equal;
        int dc, nd, bc; logic [2:0] r, r1; logic [1:0] af;
        run_op(0, 16'h5A, 16'h5A, 1'b0, 0, 10, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 9) $display("FAIL eq_done_cycle: got %0d want 9", dc); else pass_cnt++;
        total_cnt++; if (bc !== 9) $display("FAIL eq_busy_cycles: got %0d want 9", bc); else pass_cnt++;
        total_cnt++; if (r !== 3'b001) $display("FAIL eq_result: got %b want 001", r); else pass_cnt++;
        total_cnt++; if (nd !== 1 || af !== 2'b00) $display("FAIL eq_single_done: got %0d/%b want 1/00", nd, af); else pass_cnt++;
    endtask

    task automatic test_signed_unsigned;
        int dc, nd, bc; logic [2:0] r, r1; logic [1:0] af;
        run_op(0, 16'h80, 16'h7F, 1'b0, 0, 10, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 9 || r !== 3'b010) $display("FAIL unsigned_80_7f: got cyc %0d res %b want 9 010", dc, r); else pass_cnt++;
        run_op(0, 16'h80, 16'h7F, 1'b1, 0, 10, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 9 || r !== 3'b100) $display("FAIL signed_80_7f: got cyc %0d res %b want 9 100", dc, r); else pass_cnt++;
        total_cnt++; if (r1 !== 3'b010) $display("FAIL result_hold_on_start: got %b want 010", r1); else pass_cnt++;
    endtask

    task automatic test_early_exit;
        int dc, nd, bc; logic [2:0] r, r1; logic [1:0] af;
        run_op(1, 16'h80, 16'h00, 1'b0, 0, 10, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 2 || r !== 3'b010) $display("FAIL early_msb: got cyc %0d res %b want 2 010", dc, r); else pass_cnt++;
        total_cnt++; if (bc !== 2 || nd !== 1) $display("FAIL early_busy: got busy %0d done %0d want 2 1", bc, nd); else pass_cnt++;
        run_op(1, 16'h01, 16'h00, 1'b0, 0, 10, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 9 || r !== 3'b010) $display("FAIL early_lsb: got cyc %0d res %b want 9 010", dc, r); else pass_cnt++;
    endtask

    task automatic test_wide_digit;
        int dc, nd, bc; logic [2:0] r, r1; logic [1:0] af;
        run_op(2, 16'h1234, 16'h1243, 1'b0, 0, 6, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 5 || r !== 3'b100) $display("FAIL wide_1234_1243: got cyc %0d res %b want 5 100", dc, r); else pass_cnt++;
        run_op(2, 16'hFFFF, 16'h0001, 1'b1, 0, 6, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 5 || r !== 3'b100) $display("FAIL wide_signed_m1_1: got cyc %0d res %b want 5 100", dc, r); else pass_cnt++;
        run_op(2, 16'hFFFF, 16'h0001, 1'b0, 0, 6, dc, nd, bc, r, r1, af);
        total_cnt++; if (r !== 3'b010) $display("FAIL wide_unsigned_ffff_1: got %b want 010", r); else pass_cnt++;
    endtask

    task automatic test_start_while_busy;
        int dc, nd, bc; logic [2:0] r, r1, e; logic [1:0] af;
        logic [15:0] av, bv;
        run_op(0, 16'h10, 16'h20, 1'b0, (1 << 3) | (1 << 5) | (1 << 9), 9, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 9 || r !== 3'b100) $display("FAIL busy_start_ignored: got cyc %0d res %b want 9 100", dc, r); else pass_cnt++;
        total_cnt++; if (nd !== 1) $display("FAIL busy_single_done: got %0d want 1", nd); else pass_cnt++;
        total_cnt++; if (af !== 2'b00) $display("FAIL busy_low_cycle10: got busy,done %b want 00", af); else pass_cnt++;
        av = 16'($urandom_range(255));
        bv = 16'($urandom_range(255));
        e = ref_cmp(8, av, bv, 1'b0);
        run_op(0, av, bv, 1'b0, 0, 10, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 9 || r !== e) $display("FAIL back_to_back: got cyc %0d res %b want 9 %b", dc, r, e); else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        int dc, nd, bc, bad; logic [2:0] r, r1; logic [1:0] af; logic [4:0] o;
        set_ops(0, 16'h10, 16'h20, 1'b0);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = obs(0);
        total_cnt++; if (o !== 5'b0) $display("FAIL mid_reset_clear: got %b want 00000", o); else pass_cnt++;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            o = obs(0);
            if (o[3] || o[4]) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL mid_reset_no_done: got %0d active cycles want 0", bad); else pass_cnt++;
        set_start(0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_start(0, 1'b0);
        o = obs(0);
        total_cnt++; if (o[4] !== 1'b0) $display("FAIL reset_beats_start: got busy %b want 0", o[4]); else pass_cnt++;
        run_op(0, 16'h33, 16'h22, 1'b0, 0, 10, dc, nd, bc, r, r1, af);
        total_cnt++; if (dc !== 9 || r !== 3'b010) $display("FAIL after_reset_run: got cyc %0d res %b want 9 010", dc, r); else pass_cnt++;
    endtask

    task automatic test_random;
        int dc, nd, bc, w, d, n, fd, exp_dc, mode;
        logic [2:0] r, r1, e, prev;
        logic [1:0] af;
        logic [15:0] av, bv, m;
        logic sv;
        for (int sel = 0; sel < 3; sel++) begin
            w = (sel == 2) ? 16 : 8;
            d = (sel == 2) ? 4 : 1;
            n = w / d;
            m = 16'((1 << w) - 1);
            prev = 'x;
            for (int i = 0; i < 14; i++) begin
                av = 16'($urandom) & m;
                mode = $urandom_range(3);
                if (mode == 0)      bv = av;
                else if (mode == 1) bv = (av ^ (16'(1) << $urandom_range(w - 1))) & m;
                else                bv = 16'($urandom) & m;
                sv = 1'($urandom);
                e = ref_cmp(w, av, bv, sv);
                fd = ref_first_diff(w, d, av, bv);
                exp_dc = (sel == 1 && fd != 0) ? fd + 1 : n + 1;
                run_op(sel, av, bv, sv, 0, n + 2, dc, nd, bc, r, r1, af);
                total_cnt++;
                if (dc !== exp_dc || r !== e)
                    $display("FAIL rand dut%0d a=%h b=%h s=%b: got cyc %0d res %b want %0d %b", sel, av, bv, sv, dc, r, exp_dc, e);
                else pass_cnt++;
                total_cnt++;
                if (bc !== exp_dc || nd !== 1 || af !== 2'b00)
                    $display("FAIL rand_handshake dut%0d: got busy %0d done %0d after %b want %0d 1 00", sel, bc, nd, af, exp_dc);
                else pass_cnt++;
                if (i > 0) begin
                    total_cnt++;
                    if (r1 !== prev) $display("FAIL rand_hold dut%0d: got %b want %b", sel, r1, prev);
                    else pass_cnt++;
                end
                prev = e;
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_signed_unsigned();
        test_early_exit();
        test_wide_digit();
        test_start_while_busy();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
